// File: rtl/recipe_sequencer_pkg.sv
// Shared types and defaults for the beverage recipe sequencer.
package recipe_pkg;
  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE,
    ABORT
  } seq_state_t;

  localparam int ING_DEFAULT    = 5;
  localparam int DOSE_W_DEFAULT = 8;
endpackage

// File: rtl/recipe_sequencer_if.sv
// Control/valve bundle between the dose timer, the sequencer and the valve drivers.
interface recipe_sequencer_if
  import recipe_pkg::*;
#(
  parameter int N_ING = ING_DEFAULT,
  parameter int CNT_W = DOSE_W_DEFAULT
);
  localparam int STEP_W = $clog2(N_ING);

  logic                   start;
  logic                   abort;
  logic                   tick;
  logic [N_ING-1:0]       recipe_mask;
  logic [N_ING*CNT_W-1:0] dose;
  logic [N_ING-1:0]       valve;
  logic [STEP_W-1:0]      step;
  logic                   busy;
  logic                   done;
  logic                   aborted;

  modport master (
    output start, abort, tick,
    output recipe_mask, dose,
    input  valve, step, busy,
    input  done, aborted
  );

  modport slave (
    input  start, abort, tick,
    input  recipe_mask, dose,
    output valve, step, busy,
    output done, aborted
  );
endinterface

// File: rtl/recipe_sequencer_next_sel.sv
// Priority finder: lowest set mask bit, either overall or strictly above i_cur.
module next_sel #(
  parameter int N  = 5,
  parameter int SW = 3
) (
  input  logic [N-1:0]  i_mask,
  input  logic [SW-1:0] i_cur,
  input  logic          i_lowest,
  output logic          o_found,
  output logic [SW-1:0] o_idx
);
  // Descending scan so the lowest qualifying bit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_lowest || (SW'(i) > i_cur))) begin
        o_found = 1'b1;
        o_idx   = SW'(i);
      end
    end
  end
endmodule

// File: rtl/recipe_sequencer.sv
// Recipe sequencer: opens one valve at a time, in ascending channel order,
// for the latched dose of each selected channel.
module recipe_sequencer
  import recipe_pkg::*;
#(
  parameter int N_ING = ING_DEFAULT,
  parameter int CNT_W = DOSE_W_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  recipe_sequencer_if.slave bus
);
  localparam int SW = $clog2(N_ING);

  seq_state_t             r_state;
  logic [N_ING-1:0]       r_mask;
  logic [N_ING*CNT_W-1:0] r_dose;
  logic [CNT_W-1:0]       r_cnt;
  logic [SW-1:0]          r_step;
  logic [N_ING-1:0]       r_valve;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_aborted;

  logic                   w_idle;
  logic [N_ING-1:0]       w_eff;
  logic [N_ING-1:0]       w_sel_mask;
  logic [N_ING*CNT_W-1:0] w_src;
  logic                   w_found;
  logic [SW-1:0]          w_idx;
  logic [CNT_W-1:0]       w_next_dose;
  logic [N_ING-1:0]       w_onehot;

  assign w_idle = (r_state == IDLE);

  // Zero-dose channels drop out of the mask at the start edge.
  always_comb begin
    w_eff = '0;
    for (int i = 0; i < N_ING; i++) begin
      w_eff[i] = bus.recipe_mask[i] &&
                 (bus.dose[i*CNT_W +: CNT_W] != '0);
    end
  end

  assign w_sel_mask = w_idle ? w_eff : r_mask;
  assign w_src      = w_idle ? bus.dose : r_dose;

  next_sel #(
    .N  (N_ING),
    .SW (SW)
  ) u_sel (
    .i_mask   (w_sel_mask),
    .i_cur    (r_step),
    .i_lowest (w_idle),
    .o_found  (w_found),
    .o_idx    (w_idx)
  );

  always_comb begin
    w_next_dose = '0;
    w_onehot    = '0;
    for (int i = 0; i < N_ING; i++) begin
      if (w_idx == SW'(i)) begin
        w_next_dose = w_src[i*CNT_W +: CNT_W];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_dose    <= '0;
      r_cnt     <= '0;
      r_step    <= '0;
      r_valve   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mask <= w_eff;
            r_dose <= bus.dose;
            r_busy <= 1'b1;
            if (w_found) begin
              r_state <= DISPENSE;
              r_step  <= w_idx;
              r_cnt   <= w_next_dose;
              r_valve <= w_onehot;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          if (bus.abort) begin
            r_state   <= ABORT;
            r_valve   <= '0;
            r_step    <= '0;
            r_aborted <= 1'b1;
          end else if (bus.tick) begin
            if (r_cnt > CNT_W'(1)) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else if (w_found) begin
              r_step  <= w_idx;
              r_cnt   <= w_next_dose;
              r_valve <= w_onehot;
            end else begin
              r_state <= DONE;
              r_valve <= '0;
              r_step  <= '0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        ABORT: begin
          r_state   <= IDLE;
          r_aborted <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.valve   = r_valve;
  assign bus.step    = r_step;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.aborted = r_aborted;
endmodule
